// File: rtl/face_store_if.sv
// Load-word stream into face_store: one WORD_BITS word per beat.
// The beat moves on wr_valid & wr_ready. wr_last marks the final word of a load.
interface face_store_if #(
    parameter int WORD_BITS = 16
);
    logic [WORD_BITS-1:0] wr_word;
    logic                 wr_valid;
    logic                 wr_last;
    logic                 wr_ready;

    modport master (output wr_word, output wr_valid, output wr_last, input wr_ready);
    modport slave  (input wr_word, input wr_valid, input wr_last, output wr_ready);
endinterface

// File: rtl/face_store.sv
// Face memory: a word-stream loader packs faces MSB-first, and a registered read port serves the GPU fetch stage.
// Define FACE_STORE_COUNT_MASK_EN to return zero for addresses at or beyond the committed face count.
module face_store #(
    parameter  int FACES     = 92,
    parameter  int WORD_BITS = 16,
    localparam int AW        = $clog2(FACES),
    localparam int FACE_BITS = 44
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load_start,
    face_store_if.slave          wr,
    input  logic [AW-1:0]        i_mem_addr,
    output logic [FACE_BITS-1:0] o_face,
    output logic [AW:0]          o_face_count,
    output logic                 o_loaded,
    output logic                 o_load_err
);
    typedef struct packed {
        logic [11:0]           v0;
        logic [11:0]           v1;
        logic [11:0]           v2;
        logic [FACE_BITS-37:0] color;
    } face_t;

    localparam int WPF      = ($bits(face_t) + WORD_BITS - 1) / WORD_BITS;
    localparam int ASM_BITS = WPF * WORD_BITS;
    localparam int WIW      = (WPF > 1) ? $clog2(WPF) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIW-1:0]      r_word_idx, w_word_idx_nxt;
    logic [AW-1:0]       r_face_idx, w_face_idx_nxt;
    logic [AW:0]         r_face_count, w_count_nxt;
    logic                r_loaded, w_loaded_nxt;
    logic                r_load_err, w_err_nxt;
    logic [ASM_BITS-1:0] r_asm, w_asm_nxt;
    face_t               r_face;
    face_t               r_mem [FACES];

    logic                w_accept;
    logic                w_last_word;
    logic                w_we;
    logic                w_mem_we;
    logic                w_in_mask;
    logic [ASM_BITS-1:0] w_shifted;
    face_t               w_wdata;

    assign wr.wr_ready   = (r_state == S_LOAD);
    // A restart pulse wins over a word offered on the same cycle
    assign w_accept      = wr.wr_valid & (r_state == S_LOAD) & ~i_load_start;
    assign w_last_word   = (r_word_idx == WIW'(WPF - 1));
    assign w_shifted     = {r_asm[ASM_BITS-WORD_BITS-1:0], wr.wr_word};
    assign w_wdata       = w_shifted[ASM_BITS-1 -: FACE_BITS];
    assign w_mem_we      = w_we & ~i_reset;

    assign o_face        = r_face;
    assign o_face_count  = r_face_count;
    assign o_loaded      = r_loaded;
    assign o_load_err    = r_load_err;

    // Next-state and load bookkeeping
    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_face_idx_nxt = r_face_idx;
        w_count_nxt    = r_face_count;
        w_loaded_nxt   = r_loaded;
        w_err_nxt      = r_load_err;
        w_asm_nxt      = r_asm;
        w_we           = 1'b0;
        if (i_load_start) begin
            w_state_nxt    = S_LOAD;
            w_word_idx_nxt = '0;
            w_face_idx_nxt = '0;
            w_count_nxt    = '0;
            w_loaded_nxt   = 1'b0;
            w_err_nxt      = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_DONE: w_state_nxt = S_DONE;
                S_LOAD: begin
                    if (w_accept) begin
                        w_asm_nxt = w_shifted;
                        if (w_last_word) begin
                            w_we           = 1'b1;
                            w_word_idx_nxt = '0;
                            w_face_idx_nxt = r_face_idx + AW'(1);
                            w_count_nxt    = {1'b0, r_face_idx} + (AW+1)'(1);
                            if (wr.wr_last || (r_face_idx == AW'(FACES - 1))) begin
                                w_state_nxt  = S_DONE;
                                w_loaded_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = S_LOAD;
                            end
                        end else if (wr.wr_last) begin
                            // Truncated face: drop the partial record and flag it
                            w_state_nxt    = S_DONE;
                            w_err_nxt      = 1'b1;
                            w_loaded_nxt   = 1'b0;
                            w_word_idx_nxt = '0;
                        end else begin
                            w_word_idx_nxt = r_word_idx + WIW'(1);
                        end
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and load registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_word_idx   <= '0;
            r_face_idx   <= '0;
            r_face_count <= '0;
            r_loaded     <= 1'b0;
            r_load_err   <= 1'b0;
            r_asm        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_face_idx   <= w_face_idx_nxt;
            r_face_count <= w_count_nxt;
            r_loaded     <= w_loaded_nxt;
            r_load_err   <= w_err_nxt;
            r_asm        <= w_asm_nxt;
        end
    end

    // Memory write port
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_face_idx] <= w_wdata;
        end
    end

`ifdef FACE_STORE_COUNT_MASK_EN
    assign w_in_mask = ({1'b0, i_mem_addr} < r_face_count);
`else
    assign w_in_mask = 1'b1;
`endif

    // Registered read port; a same-edge write is not visible (read-first)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_face <= '0;
        end else if (({1'b0, i_mem_addr} < (AW+1)'(FACES)) && w_in_mask) begin
            r_face <= r_mem[i_mem_addr];
        end else begin
            r_face <= '0;
        end
    end
endmodule

// File: doc/face_store.md
Name: face_store

Overview:
- Face memory that answers the graphics engine's fetch stage: takes `mem_addr` and returns the addressed `Face_t` one cycle later.
- Also the load side of that memory. A host or loader streams 16-bit words in over a valid/ready handshake; the block packs them into `Face_t` records and writes them to consecutive addresses.
- Sits between the scene loader and the GPU fetch counter.

Parameters:
- FACES, 92, number of face slots; address width is $clog2(FACES).
- WORD_BITS, 16, width of one load word.
- WORDS_PER_FACE, ($bits(Face_t)+WORD_BITS-1)/WORD_BITS, load words per face.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a new load at face 0.
- wr_word  in  WORD_BITS  load data word.
- wr_valid  in  1  wr_word valid.
- wr_last  in  1  marks the final word of the final face; qualified by wr_valid.
- wr_ready  out  1  block accepts a word this cycle.
- mem_addr  in  $clog2(FACES)  read address from the GPU fetch stage.
- face  out  $bits(Face_t)  read data (Face_t), registered.
- face_count  out  $clog2(FACES)+1  number of faces committed by the last load.
- loaded  out  1  a load completed without error.
- load_err  out  1  sticky error from the last load.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, wr_ready=0, face='0, face_count=0, loaded=0, load_err=0.
  - Word and face indices clear to 0.
  - Memory contents are not cleared.
- States: IDLE, LOAD, DONE.
- IDLE/DONE, load_start=1:
  - Go to LOAD.
  - word_idx=0, face_idx=0, face_count=0, loaded=0, load_err=0.
- LOAD: wr_ready=1 combinationally. In all other states wr_ready=0.
- LOAD, load_start=1: the load restarts (indices and flags clear as above). Any word offered that cycle is dropped.
- Word accept = wr_valid & wr_ready.
  - The accepted word shifts into the assembly register, MSB-first: the first word is the top WORD_BITS of Face_t.
  - Any pad bits in the final word are discarded (low-order pad).
- Accept with word_idx==WORDS_PER_FACE-1 (face commit):
  - Write the assembled face to mem[face_idx] on the same edge.
  - face_idx++, word_idx=0, face_count=face_idx+1.
- Commit with face_idx==FACES-1 and wr_last=0: go to DONE, loaded=1.
- Commit with wr_last=1: go to DONE, loaded=1, face_count=face_idx+1. Early end is legal.
- Accept of wr_last=1 on a non-final word:
  - The partial face is discarded; nothing is written.
  - Go to DONE, load_err=1, loaded=0.
  - face_count holds the number of complete faces.
- Reads:
  - Every cycle, face <= mem[mem_addr] (1-cycle latency), in all states, including during LOAD.
  - If the read and write addresses collide on the same edge, the read returns old data (read-first).
  - mem_addr >= FACES: face <= '0.
- DONE: holds. Only load_start or reset leaves DONE. wr_valid is ignored.
- Reset during LOAD: abort immediately. Faces already written stay in memory; face_count=0, loaded=0.
- The memory is a single write port plus a single synchronous read port, so it infers as BRAM.

Optional Feature:
- Macro: FACE_STORE_COUNT_MASK_EN.
- Defined:
  - Reads with mem_addr >= face_count return '0, so stale faces from earlier loads never reach the pipeline.
  - While loaded=0 (during LOAD, and after an error), face_count still gates the mask, so only committed faces read back.
- Undefined: no masking; reads return raw memory contents for any mem_addr < FACES.

Test Plan:
- Reset, then mem_addr=0 → face='0, wr_ready=0, loaded=0, face_count=0.
- load_start, then FACES*WORDS_PER_FACE words with a counting pattern (word n = n), wr_valid=1 continuously, wr_last on the final word:
  - Exactly one DONE transition; loaded=1, face_count=92.
  - Reading address k returns face k, MSB-first packed, one cycle after mem_addr=k.
- Load 3 faces with wr_last on the last word of face 2 → face_count=3, loaded=1, state DONE, wr_ready=0.
- Toggle wr_valid randomly during a 2-face load → identical memory contents to the gap-free load; no words are dropped or duplicated.
- wr_last on word 1 of face 1 (WORDS_PER_FACE > 2) → load_err=1, loaded=0, face_count=1, mem[1] unchanged.
- Mask on (FACE_STORE_COUNT_MASK_EN defined), 3-face load over a prior 92-face load: mem_addr=5 → face='0; mem_addr=2 → new face 2. Mask off: mem_addr=5 → the old face 5.
